// File: rtl/param_frame_tx_pkg.sv
// param_frame_tx_pkg: frame layout and FSM encoding shared by the transmit and capture sides of the parameter link
// Exports NWORDS, the SLOT_* word positions (the single definition of the frame order) and the ST_* state codes.
package param_frame_tx_pkg;
  localparam int NWORDS = 6;
  localparam logic [2:0] SLOT_AMP1   = 3'd0;
  localparam logic [2:0] SLOT_AMP2   = 3'd1;
  localparam logic [2:0] SLOT_PHASE1 = 3'd2;
  localparam logic [2:0] SLOT_PHASE2 = 3'd3;
  localparam logic [2:0] SLOT_FRE1   = 3'd4;
  localparam logic [2:0] SLOT_FRE2   = 3'd5;
  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_SEND     = 2'd1;
  localparam logic [1:0] ST_GAP_WAIT = 2'd2;
  localparam logic [1:0] ST_FINISH   = 2'd3;
endpackage

// File: rtl/param_frame_tx_if.sv
// param_frame_tx_if: request, payload and paced word stream of the parameter frame transmitter
// master drives en/start/payload/out_ready and observes data_out/po_flag/idx/busy/done; slave is the transmitter.
interface param_frame_tx_if #(parameter int DW = 16);
  logic en, start, out_ready;
  logic [DW-1:0] amp1, amp2, phase1, phase2, fre1, fre2;
  logic [DW-1:0] data_out;
  logic po_flag, busy, done;
  logic [2:0] idx;
  modport master (
    output en, start, out_ready, amp1, amp2, phase1, phase2, fre1, fre2,
    input data_out, po_flag, idx, busy, done
  );
  modport slave (
    input en, start, out_ready, amp1, amp2, phase1, phase2, fre1, fre2,
    output data_out, po_flag, idx, busy, done
  );
endinterface

// File: rtl/param_frame_tx_gap_timer.sv
// gap_timer: loadable down-counter that times the idle gap between frame words
// clk/rst_n: clock, async active-low reset; clr: sync clear; load/load_val: start a count; expired: count is zero.
module gap_timer #(parameter int W = 8) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);
  logic [W-1:0] cnt;
  assign expired = cnt == '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= clr ? '0 : load ? load_val : expired ? cnt : cnt - 1'b1;
endmodule

// File: rtl/param_frame_tx.sv
// param_frame_tx: snapshots the six-word parameter frame on start and emits it as a paced, back-pressured word stream
// clk/rst_n: clock, async active-low reset; bus (slave): en, start, payload and out_ready in;
// data_out/idx/po_flag word strobe, busy while a frame is in progress, done pulse after the sixth word.
module param_frame_tx import param_frame_tx_pkg::*; #(
  parameter int DW  = 16,
  parameter int GAP = 0
) (
  input logic clk,
  input logic rst_n,
  param_frame_tx_if.slave bus
);
  logic [1:0] state;
  logic [2:0] ptr;
  logic [DW-1:0] shadow [NWORDS];
  logic accept, emit, last, gap_expired;
  assign accept = bus.en && bus.start && state == ST_IDLE;
  assign emit = bus.en && bus.out_ready && state == ST_SEND;
  assign last = ptr == SLOT_FRE2;
  // The timer is loaded with GAP-1 so that GAP_WAIT lasts exactly GAP cycles including the expiring one.
  gap_timer #(.W(8)) u_gap (
    .clk(clk),
    .rst_n(rst_n),
    .clr(!bus.en),
    .load(emit && !last && GAP > 0),
    .load_val(8'(GAP > 0 ? GAP - 1 : 0)),
    .expired(gap_expired)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= ST_IDLE;
      ptr <= '0;
      shadow <= '{default: '0};
      bus.data_out <= '0;
      bus.idx <= '0;
      bus.po_flag <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
    end else if (!bus.en) begin
      state <= ST_IDLE;
      ptr <= '0;
      bus.data_out <= '0;
      bus.idx <= '0;
      bus.po_flag <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      bus.po_flag <= emit;
      bus.done <= state == ST_FINISH;
      // busy spans through the done cycle; a start accepted during done keeps it high.
      bus.busy <= accept ? 1'b1 : bus.done ? 1'b0 : bus.busy;
      if (accept) begin
        shadow[SLOT_AMP1] <= bus.amp1;
        shadow[SLOT_AMP2] <= bus.amp2;
        shadow[SLOT_PHASE1] <= bus.phase1;
        shadow[SLOT_PHASE2] <= bus.phase2;
        shadow[SLOT_FRE1] <= bus.fre1;
        shadow[SLOT_FRE2] <= bus.fre2;
        ptr <= '0;
      end
      if (emit) begin
        bus.data_out <= shadow[ptr];
        bus.idx <= ptr;
        if (!last) ptr <= ptr + 3'd1;
      end
      state <= accept ? ST_SEND :
               emit ? (last ? ST_FINISH : GAP > 0 ? ST_GAP_WAIT : ST_SEND) :
               (state == ST_GAP_WAIT && gap_expired) ? ST_SEND :
               state == ST_FINISH ? ST_IDLE : state;
    end
endmodule

// File: tb/tb_param_frame_tx.sv
// tb_param_frame_tx: self-checking bench running GAP=0 and GAP=3 transmitters side by side against a word-schedule model
module tb_param_frame_tx;
  import param_frame_tx_pkg::*;
  localparam int DW = 16;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic start = 1'b0;
  logic out_ready = 1'b0;
  logic [DW-1:0] pay [NWORDS];
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  for (genvar g = 0; g < 2; g++) begin : inst
    localparam int G = g ? 3 : 0;
    param_frame_tx_if #(.DW(DW)) bus ();
    assign bus.en = en;
    assign bus.start = start;
    assign bus.out_ready = out_ready;
    assign bus.amp1 = pay[0];
    assign bus.amp2 = pay[1];
    assign bus.phase1 = pay[2];
    assign bus.phase2 = pay[3];
    assign bus.fre1 = pay[4];
    assign bus.fre2 = pay[5];
    param_frame_tx #(.DW(DW), .GAP(G)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
    logic [DW-1:0] frame [NWORDS];
    logic [DW-1:0] cap [NWORDS];
    logic [DW-1:0] m_data;
    logic [2:0] m_idx;
    logic m_po, m_done, m_busy;
    int cyc = 0;
    int k = 0;
    int elig = 0;
    bit active, fin, drop, was;
    // Model: word k becomes eligible GAP+1 edges after word k-1 and goes out on the first eligible edge with
    // out_ready high; done follows the sixth word by one edge and busy drops one edge after done.
    initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n || !en) begin
        m_data = '0;
        m_idx = '0;
        m_po = 1'b0;
        m_done = 1'b0;
        m_busy = 1'b0;
        active = 1'b0;
        fin = 1'b0;
        drop = 1'b0;
      end else begin
        was = active;
        m_po = 1'b0;
        m_done = 1'b0;
        if (drop) begin
          m_busy = 1'b0;
          drop = 1'b0;
        end
        if (fin) begin
          m_done = 1'b1;
          fin = 1'b0;
          active = 1'b0;
          drop = 1'b1;
        end else if (was && cyc >= elig && out_ready) begin
          m_po = 1'b1;
          m_data = frame[k];
          m_idx = 3'(k);
          if (k == NWORDS - 1) fin = 1'b1;
          else begin
            k++;
            elig = cyc + G + 1;
          end
        end
        if (!was && start) begin
          frame = pay;
          active = 1'b1;
          k = 0;
          elig = cyc + 1;
          m_busy = 1'b1;
          drop = 1'b0;
        end
      end
      cyc++;
    end
    initial forever begin
      @(negedge clk);
      check($sformatf("g%0d po_flag", G), 32'(bus.po_flag), 32'(m_po));
      check($sformatf("g%0d idx", G), 32'(bus.idx), 32'(m_idx));
      check($sformatf("g%0d data_out", G), 32'(bus.data_out), 32'(m_data));
      check($sformatf("g%0d done", G), 32'(bus.done), 32'(m_done));
      check($sformatf("g%0d busy", G), 32'(bus.busy), 32'(m_busy));
      if (bus.po_flag && bus.idx < 3'(NWORDS)) cap[bus.idx] = bus.data_out;
      if (m_done)
        for (int i = 0; i < NWORDS; i++) check($sformatf("g%0d capture slot %0d", G, i), 32'(cap[i]), 32'(frame[i]));
    end
  end
  task automatic set_base();
    for (int i = 0; i < NWORDS; i++) pay[i] = DW'(16'h0011 * (i + 1));
  endtask
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic wait_slot(input logic [2:0] s);
    int n = 0;
    while (!(inst[0].bus.po_flag && inst[0].bus.idx == s) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n == 40) check("wait_slot timeout", 32'd0, 32'd1);
  endtask
  initial begin
    set_base();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    en = 1'b1;
    out_ready = 1'b1;
    pulse_start();
    repeat (30) @(negedge clk);
    pulse_start();
    wait_slot(3'd1);
    out_ready = 1'b0;
    repeat (4) @(negedge clk);
    out_ready = 1'b1;
    repeat (40) @(negedge clk);
    pulse_start();
    for (int i = 0; i < NWORDS; i++) pay[i] = '1;
    repeat (2) @(negedge clk);
    pulse_start();
    repeat (30) @(negedge clk);
    set_base();
    pulse_start();
    wait_slot(3'd3);
    en = 1'b0;
    repeat (2) @(negedge clk);
    en = 1'b1;
    pulse_start();
    repeat (30) @(negedge clk);
    en = 1'b0;
    start = 1'b1;
    @(negedge clk);
    en = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    for (int c = 0; c < 1500; c++) begin
      out_ready = $urandom_range(0, 9) < 7;
      start = $urandom_range(0, 19) == 0;
      en = $urandom_range(0, 99) != 0;
      if ($urandom_range(0, 3) == 0)
        for (int i = 0; i < NWORDS; i++) pay[i] = DW'($urandom);
      @(negedge clk);
    end
    en = 1'b1;
    start = 1'b0;
    out_ready = 1'b1;
    repeat (40) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
